otp_pad_scheduler: RTL and testbench

//  Sequences and arbitrates the OTP pad store between an encrypt requester and a decrypt requester.

---
 rtl/otp_pkg.sv | 11 +
 rtl/otp_free_slot_finder.sv | 22 ++
 rtl/otp_pad_scheduler.sv | 114 +++++++++++
 tb/tb_otp_pad_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared widths and enums for the OTP pad scheduler and its helpers.
package otp_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DEPTH  = 2 ** IDX_W;

   typedef enum logic {IDLE, GRANT} state_e;
   typedef enum logic {ENC, DEC} req_e;

endpackage

// File: rtl/otp_free_slot_finder.sv
// Priority encoder: lowest-index slot whose valid bit is clear.
module otp_free_slot_finder
   import otp_pkg::*;
(
   input  logic [DEPTH-1:0] valid,
   output logic [IDX_W-1:0] free_idx,
   output logic             any_free
);

   // Scan high to low so the lowest free slot is the last one written.
   always_comb begin
      free_idx = '0;
      any_free = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            free_idx = IDX_W'(i);
            any_free = 1'b1;
         end
      end
   end

endmodule

// File: rtl/otp_pad_scheduler.sv
// Arbitrates encrypt/decrypt requesters over a one-time pad store; each pad is consumed once.
module otp_pad_scheduler
   import otp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [DATA_W-1:0] pad_in,
   input  logic              enc_req,
   input  logic [DATA_W-1:0] enc_data,
   output logic              enc_ack,
   input  logic              dec_req,
   input  logic [IDX_W-1:0]  dec_idx,
   input  logic [DATA_W-1:0] dec_data,
   output logic              dec_ack,
   output logic [DATA_W-1:0] res_data,
   output logic [IDX_W-1:0]  res_idx,
   output logic              res_err,
   output logic              full,
   output logic              empty
);

   state_e              state_q, state_d;
   req_e                rr_last_q;
   logic [DEPTH-1:0]    valid_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                enc_ack_q, dec_ack_q, res_err_q;
   logic [DATA_W-1:0]   res_data_q;
   logic [IDX_W-1:0]    res_idx_q;

   logic [IDX_W-1:0]    free_idx;
   logic                any_free;
   logic                grant_any;
   logic                grant_enc;

   otp_free_slot_finder u_free_slot_finder (
      .valid    (valid_q),
      .free_idx (free_idx),
      .any_free (any_free)
   );

   assign full  = ~any_free;
   assign empty = ~|valid_q;

   // Requests are only sampled in IDLE, so a request held through its own ack is not re-served.
   always_comb begin
      state_d   = state_q;
      grant_any = 1'b0;
      grant_enc = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_any = ena && (enc_req || dec_req);
            grant_enc = enc_req && (!dec_req || (rr_last_q == DEC));
            if (grant_any) state_d = GRANT;
         end
         GRANT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_last_q  <= DEC;
         valid_q    <= '0;
         enc_ack_q  <= 1'b0;
         dec_ack_q  <= 1'b0;
         res_err_q  <= 1'b0;
         res_data_q <= '0;
         res_idx_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         enc_ack_q <= 1'b0;
         dec_ack_q <= 1'b0;
         if (grant_any) begin
            if (grant_enc) begin
               enc_ack_q <= 1'b1;
               rr_last_q <= ENC;
               if (any_free) begin
                  mem_q[free_idx]   <= pad_in;
                  valid_q[free_idx] <= 1'b1;
                  res_data_q        <= enc_data ^ pad_in;
                  res_idx_q         <= free_idx;
                  res_err_q         <= 1'b0;
               end else begin
                  res_data_q <= '0;
                  res_idx_q  <= '0;
                  res_err_q  <= 1'b1;
               end
            end else begin
               dec_ack_q <= 1'b1;
               rr_last_q <= DEC;
               res_idx_q <= dec_idx;
               if (valid_q[dec_idx]) begin
                  res_data_q       <= mem_q[dec_idx] ^ dec_data;
                  valid_q[dec_idx] <= 1'b0;
                  res_err_q        <= 1'b0;
               end else begin
                  res_data_q <= '0;
                  res_err_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign enc_ack  = enc_ack_q;
   assign dec_ack  = dec_ack_q;
   assign res_data = res_data_q;
   assign res_idx  = res_idx_q;
   assign res_err  = res_err_q;

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Directed and random bench for otp_pad_scheduler against a slot-table reference model.
module tb_otp_pad_scheduler;
   import otp_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n, ena;
   logic [DATA_W-1:0] pad_in, enc_data, dec_data;
   logic              enc_req, dec_req;
   logic [IDX_W-1:0]  dec_idx;
   logic              enc_ack, dec_ack, res_err, full, empty;
   logic [DATA_W-1:0] res_data;
   logic [IDX_W-1:0]  res_idx;

   int checks = 0;
   int errors = 0;

   // Reference model: a table of slots, each either free or holding a pad.
   bit         m_valid [8];
   logic [7:0] m_pad   [8];
   bit         m_last_dec;
   logic [7:0] e_data;
   logic [2:0] e_idx;
   logic       e_err;

   otp_pad_scheduler dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .pad_in   (pad_in),
      .enc_req  (enc_req),
      .enc_data (enc_data),
      .enc_ack  (enc_ack),
      .dec_req  (dec_req),
      .dec_idx  (dec_idx),
      .dec_data (dec_data),
      .dec_ack  (dec_ack),
      .res_data (res_data),
      .res_idx  (res_idx),
      .res_err  (res_err),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(m_valid[i]);
      return n;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_pad[i]   = 8'h00;
      end
      m_last_dec = 1'b1;
   endtask

   task automatic m_enc(input logic [7:0] d, input logic [7:0] p);
      int slot = -1;
      for (int i = 0; i < 8; i++) if (!m_valid[i] && slot < 0) slot = i;
      m_last_dec = 1'b0;
      if (slot < 0) begin
         e_data = 8'h00; e_idx = 3'd0; e_err = 1'b1;
      end else begin
         m_valid[slot] = 1'b1;
         m_pad[slot]   = p;
         e_data = d ^ p; e_idx = 3'(slot); e_err = 1'b0;
      end
   endtask

   task automatic m_dec(input logic [2:0] idx, input logic [7:0] d);
      m_last_dec = 1'b1;
      e_idx = idx;
      if (m_valid[idx]) begin
         e_data = m_pad[idx] ^ d; e_err = 1'b0;
         m_valid[idx] = 1'b0;
      end else begin
         e_data = 8'h00; e_err = 1'b1;
      end
   endtask

   task automatic chk_result(input string tag, input bit is_enc);
      chk({tag, "_enc_ack"}, enc_ack, is_enc);
      chk({tag, "_dec_ack"}, dec_ack, !is_enc);
      chk({tag, "_res_data"}, res_data, e_data);
      chk({tag, "_res_idx"}, res_idx, e_idx);
      chk({tag, "_res_err"}, res_err, e_err);
      chk({tag, "_full"}, full, m_count() == 8);
      chk({tag, "_empty"}, empty, m_count() == 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enc_req = 1'b0; dec_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_reset();
   endtask

   task automatic do_enc(input string tag, input logic [7:0] d, input logic [7:0] p);
      m_enc(d, p);
      enc_data = d; pad_in = p; enc_req = 1'b1;
      @(posedge clk); #1;
      enc_req = 1'b0;
      chk_result(tag, 1'b1);
      @(posedge clk); #1;
      chk({tag, "_ack_drop"}, enc_ack, 1'b0);
   endtask

   task automatic do_dec(input string tag, input logic [2:0] idx, input logic [7:0] d);
      m_dec(idx, d);
      dec_idx = idx; dec_data = d; dec_req = 1'b1; pad_in = 8'($urandom);
      @(posedge clk); #1;
      dec_req = 1'b0;
      chk_result(tag, 1'b0);
      @(posedge clk); #1;
      chk({tag, "_ack_drop"}, dec_ack, 1'b0);
   endtask

   initial begin
      ena = 1'b1; pad_in = '0; enc_data = '0; dec_data = '0; dec_idx = '0;
      enc_req = 1'b0; dec_req = 1'b0; rst_n = 1'b0;
      @(posedge clk); #1;
      do_reset();
      chk("rst_enc_ack", enc_ack, 1'b0);
      chk("rst_dec_ack", dec_ack, 1'b0);
      chk("rst_res_err", res_err, 1'b0);
      chk("rst_res_data", res_data, 8'h00);
      chk("rst_res_idx", res_idx, 3'd0);
      chk("rst_full", full, 1'b0);
      chk("rst_empty", empty, 1'b1);

      // Fill the store, then overflow it.
      for (int i = 0; i < 8; i++) do_enc("fill", 8'h00, 8'hA0 + 8'(i));
      chk("fill_full", full, 1'b1);
      do_enc("overflow", 8'h00, 8'hEE);
      chk("overflow_err", res_err, 1'b1);

      // Round trip and single use of a pad.
      do_reset();
      do_enc("rt_enc", 8'h5A, 8'h3C);
      chk("rt_cipher", res_data, 8'h66);
      do_dec("rt_dec", 3'd0, 8'h66);
      chk("rt_plain", res_data, 8'h5A);
      do_dec("rt_reuse", 3'd0, 8'h66);
      chk("rt_reuse_err", res_err, 1'b1);

      // Freed hole below the top is reused first.
      do_reset();
      for (int i = 0; i < 3; i++) do_enc("hole_fill", 8'(i), 8'($urandom));
      do_dec("hole_dec", 3'd1, 8'h00);
      do_enc("hole_enc", 8'h42, 8'h24);
      chk("hole_idx", res_idx, 3'd1);

      // Both requesters held: grants alternate, starting with encrypt.
      do_reset();
      enc_data = 8'h11; dec_data = 8'h22; dec_idx = 3'd0; pad_in = 8'h77;
      enc_req = 1'b1; dec_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         chk("tie_not_both", enc_ack && dec_ack, 1'b0);
         if (k % 2 == 1) begin
            if (m_last_dec) begin
               m_enc(8'h11, 8'h77);
               chk_result("tie_enc", 1'b1);
            end else begin
               m_dec(3'd0, 8'h22);
               chk_result("tie_dec", 1'b0);
            end
         end else begin
            chk("tie_gap", enc_ack || dec_ack, 1'b0);
         end
      end
      enc_req = 1'b0; dec_req = 1'b0;
      @(posedge clk); #1;

      // Enable low holds IDLE; ack one cycle after enable rises.
      do_reset();
      ena = 1'b0; enc_data = 8'h12; pad_in = 8'h34; enc_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("ena_hold_ack", enc_ack, 1'b0);
         chk("ena_hold_empty", empty, 1'b1);
      end
      ena = 1'b1;
      m_enc(8'h12, 8'h34);
      @(posedge clk); #1;
      enc_req = 1'b0;
      chk_result("ena_rise", 1'b1);
      @(posedge clk); #1;

      // Reset right after a grant, and reset on the would-be grant edge.
      enc_data = 8'h01; pad_in = 8'h02; enc_req = 1'b1;
      m_enc(8'h01, 8'h02);
      @(posedge clk); #1;
      chk_result("rstmid_grant", 1'b1);
      rst_n = 1'b0; enc_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; m_reset();
      chk("rstmid_ack", enc_ack, 1'b0);
      chk("rstmid_empty", empty, 1'b1);
      chk("rstmid_full", full, 1'b0);
      rst_n = 1'b0; enc_req = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1; enc_req = 1'b0;
      chk("rstedge_ack", enc_ack, 1'b0);
      chk("rstedge_empty", empty, 1'b1);
      @(posedge clk); #1;

      // Random single-requester traffic.
      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 2) != 0) do_enc("rnd_enc", 8'($urandom), 8'($urandom));
         else do_dec("rnd_dec", 3'($urandom_range(0, 7)), 8'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
